// File: rtl/stack_pkg.sv
// Shared types for the operand stack and the ALU that sits beside it:
// command and ALU-operation encodings, default stack depth, and the
// unary/binary classification of ALU operations.
package stack_pkg;

   localparam int STACK_DEPTH_DEFAULT = 8;
   localparam int STACK_DATA_W        = 8;

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_PUSH = 3'd1,
      CMD_POP  = 3'd2,
      CMD_DUP  = 3'd3,
      CMD_SWAP = 3'd4,
      CMD_ALU  = 3'd5
   } stack_cmd_e;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_INC = 4'd7,
      OP_DEC = 4'd8,
      OP_NEG = 4'd9,
      OP_NOT = 4'd10
   } alu_op_e;

   // Unary operations consume only the top entry; everything else consumes two.
   function automatic logic is_unary(input alu_op_e op);
      return (op == OP_INC) || (op == OP_DEC) || (op == OP_NEG) || (op == OP_NOT);
   endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x 8 entries, asynchronous reads of the top and
// second entries, one synchronous write port and an in-place swap of the
// two entries addressed by the read ports. Contents are not reset.
module stack_regfile
   import stack_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic [$clog2(DEPTH)-1:0]   top_addr,
   input  logic [$clog2(DEPTH)-1:0]   sec_addr,
   output logic [STACK_DATA_W-1:0]    top_data,
   output logic [STACK_DATA_W-1:0]    sec_data,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [STACK_DATA_W-1:0]    wdata,
   input  logic                       swap
);

   logic [STACK_DATA_W-1:0] mem [DEPTH];

   assign top_data = mem[top_addr];
   assign sec_data = mem[sec_addr];

   // Swap has priority; the controller never requests both in one cycle.
   always_ff @(posedge clk) begin
      if (swap) begin
         mem[top_addr] <= mem[sec_addr];
         mem[sec_addr] <= mem[top_addr];
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/operand_stack.sv
// Operand stack controller: accepts stack commands, sequences ALU
// operations through an external ALU and writes the result back.
// Optional feature macro: STACK_ERR_EN -- when defined, an accepted illegal
// command sets a sticky err flag that blocks further commands until rst.
//
// state | meaning
// IDLE  | ready for a command; PUSH/POP/DUP/SWAP complete here in one cycle
// EXEC  | ALU operands registered, external ALU settling
// WB    | alu_result written into the stack, depth adjusted for binary ops
module operand_stack
   import stack_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  stack_cmd_e                 cmd,
   input  alu_op_e                    cmd_op,
   input  logic [STACK_DATA_W-1:0]    push_data,
   output logic [STACK_DATA_W-1:0]    alu_a,
   output logic [STACK_DATA_W-1:0]    alu_b,
   output alu_op_e                    alu_op,
   input  logic [STACK_DATA_W-1:0]    alu_result,
   output logic [STACK_DATA_W-1:0]    tos,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       empty,
   output logic                       full,
   output logic                       busy,
   output logic                       err
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   state_e                  state;
   logic [DW-1:0]           depth_m1;
   logic [DW-1:0]           depth_m2;
   logic [AW-1:0]           top_addr;
   logic [AW-1:0]           sec_addr;
   logic [STACK_DATA_W-1:0] top_data;
   logic [STACK_DATA_W-1:0] sec_data;
   logic                    accept;
   logic                    legal;
   logic                    exec_ok;
   logic                    rf_we;
   logic [AW-1:0]           rf_waddr;
   logic [STACK_DATA_W-1:0] rf_wdata;
   logic                    rf_swap;

   assign depth_m1 = depth - DW'(1);
   assign depth_m2 = depth - DW'(2);
   assign top_addr = depth_m1[AW-1:0];
   assign sec_addr = depth_m2[AW-1:0];

   assign empty     = (depth == '0);
   assign full      = (depth == DW'(DEPTH));
   assign busy      = (state != S_IDLE);
   assign cmd_ready = (state == S_IDLE) && !err;
   assign accept    = cmd_valid && cmd_ready;
   assign exec_ok   = accept && legal;
   assign tos       = empty ? '0 : top_data;

   // Command legality against the current depth; unknown encodings act as NOP.
   always_comb begin
      legal = 1'b1;
      case (cmd)
         CMD_PUSH: legal = !full;
         CMD_POP:  legal = !empty;
         CMD_DUP:  legal = !empty && !full;
         CMD_SWAP: legal = (depth >= DW'(2));
         CMD_ALU:  legal = is_unary(cmd_op) ? !empty : (depth >= DW'(2));
         default:  legal = 1'b1;
      endcase
   end

   // Storage write port: ALU writeback in WB, otherwise push/dup/swap on accept.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = top_addr;
      rf_wdata = alu_result;
      rf_swap  = 1'b0;
      if (state == S_WB) begin
         rf_we    = 1'b1;
         rf_waddr = is_unary(alu_op) ? top_addr : sec_addr;
         rf_wdata = alu_result;
      end else if (exec_ok) begin
         case (cmd)
            CMD_PUSH: begin
               rf_we    = 1'b1;
               rf_waddr = depth[AW-1:0];
               rf_wdata = push_data;
            end
            CMD_DUP: begin
               rf_we    = 1'b1;
               rf_waddr = depth[AW-1:0];
               rf_wdata = top_data;
            end
            CMD_SWAP: rf_swap = 1'b1;
            default:  rf_swap = 1'b0;
         endcase
      end
   end

   stack_regfile #(.DEPTH(DEPTH)) u_regfile (
      .clk      (clk),
      .top_addr (top_addr),
      .sec_addr (sec_addr),
      .top_data (top_data),
      .sec_data (sec_data),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .swap     (rf_swap)
   );

   // Sequencing FSM, depth counter and registered ALU operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         depth  <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= OP_ADD;
      end else begin
         case (state)
            S_IDLE: begin
               if (exec_ok) begin
                  case (cmd)
                     CMD_PUSH, CMD_DUP: depth <= depth + DW'(1);
                     CMD_POP:           depth <= depth_m1;
                     CMD_ALU: begin
                        alu_a  <= is_unary(cmd_op) ? '0 : sec_data;
                        alu_b  <= top_data;
                        alu_op <= cmd_op;
                        state  <= S_EXEC;
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
            S_EXEC: state <= S_WB;
            S_WB: begin
               if (!is_unary(alu_op)) depth <= depth_m1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef STACK_ERR_EN
   // Sticky error: any accepted illegal command latches err until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept && !legal) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, stack entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd  input  stack_cmd_e  NOP/PUSH/POP/DUP/SWAP/ALU.
REQ-007 SHALL have port cmd_op  input  alu_op_e  operation for cmd==ALU.
REQ-008 SHALL have port push_data  input  8  value for PUSH.
REQ-009 SHALL have ports alu_a, alu_b  output  8 each, registered operands to the ALU.
REQ-010 SHALL have port alu_op  output  alu_op_e  registered operation to the ALU.
REQ-011 SHALL have port alu_result  input  8  combinational ALU output.
REQ-012 SHALL have port tos  output  8  top-of-stack, 0 when empty.
REQ-013 SHALL have port depth  output  $clog2(DEPTH)+1  entry count.
REQ-014 SHALL have ports empty, full, busy, err  output  1 each.

Function
REQ-015 SHALL run FSM IDLE -> EXEC -> WB -> IDLE; only an accepted ALU command leaves IDLE.
REQ-016 SHALL drive cmd_ready = (state==IDLE) && !err; busy = (state!=IDLE).
REQ-017 PUSH SHALL write push_data at entry depth and increment depth in the accept cycle.
REQ-018 POP SHALL decrement depth; DUP SHALL push a copy of tos; SWAP SHALL exchange top two entries; NOP SHALL change nothing.
REQ-019 Unary ALU ops (INC, DEC, NEG, NOT) SHALL, on accept, register alu_a=0, alu_b=tos, alu_op=cmd_op and enter EXEC.
REQ-020 Binary ALU ops (all others) SHALL register alu_a=second entry, alu_b=tos, alu_op=cmd_op and enter EXEC.
REQ-021 EXEC SHALL last one cycle (ALU settles); in WB alu_result SHALL be captured into the stack: unary replaces top, binary pops two and pushes one (depth-1).
REQ-022 Updated tos/depth SHALL be visible the cycle after WB; ALU command occupancy is 3 cycles, PUSH/POP/DUP/SWAP occupancy 1 cycle (back-to-back).
REQ-023 Arithmetic SHALL be modulo 2^8; no carry, overflow or status flags produced.
REQ-024 Illegal command: PUSH/DUP when full; POP/DUP/unary when empty; SWAP/binary when depth<2.
REQ-025 An illegal command SHALL NOT modify stack contents, depth or FSM state.
REQ-026 cmd, cmd_op, push_data SHALL be ignored when not accepted; alu_a/alu_b/alu_op SHALL hold between ALU commands.

Reset
REQ-027 rst SHALL immediately force state=IDLE, depth=0, tos=0, alu_a=alu_b=0, alu_op=ADD, err=0, empty=1, full=0, busy=0.
REQ-028 rst asserted during EXEC or WB SHALL abandon the operation with no writeback; storage contents need not be cleared.
REQ-029 After rst deasserts, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-030 With STACK_ERR_EN defined, an accepted illegal command SHALL set err (sticky until rst), forcing cmd_ready=0 thereafter.
REQ-031 Without STACK_ERR_EN, err SHALL be tied 0 and an illegal command SHALL be accepted and consumed as a NOP.

Structure
REQ-032 stack_cmd_e, alu_op_e and default depth constant SHALL live in shared package stack_pkg, imported by this block and the ALU.
REQ-033 Storage SHALL be sub-module stack_regfile (DEPTH x 8, two async read ports for top/second, one write port, swap support); FSM and depth counter stay in operand_stack.
REQ-034 The ALU SHALL NOT be instantiated inside this block; the enclosing top connects alu_a/alu_b/alu_op/alu_result.

Verification
REQ-035 PUSH 5, PUSH 3, ALU SUB -> alu_a=5, alu_b=3 in EXEC; after WB tos=2, depth=1; cmd_ready low exactly 2 cycles.
REQ-036 PUSH 0x80, ALU NEG -> tos=0x80, depth=1; PUSH 0xFF, ALU INC -> tos=0x00.
REQ-037 Push DEPTH values 1..8, then PUSH 9 -> full=1, depth=8, tos=8; with STACK_ERR_EN err=1 and cmd_ready=0; without, cmd_ready stays 1.
REQ-038 From reset: POP -> depth=0, empty=1; with STACK_ERR_EN err=1, without err=0.
REQ-039 PUSH 7, PUSH 2, SWAP, DUP -> tos=7, depth=3; ALU SHL -> tos=0x80 (7<<7 truncated), depth=2.
REQ-040 PUSH 4, PUSH 6, ALU ADD, assert rst in EXEC -> depth=0, tos=0, busy=0 immediately; no writeback after release.
